// File: rtl/needs_engine.sv
// needs_engine: owns the pet's food/health levels, applies time-based decay,
// answers feed/heal command pulses with an Activo_* busy window and latches
// the dead condition until reset.
// Optional build macro NEEDS_CMD_QUEUE_EN: a one-deep pending command that is
// captured while busy and served once the block is back in IDLE.
module needs_engine #(
   parameter int TICK_DIV           = 50_000_000,
   parameter int FOOD_DECAY_TICKS   = 10,
   parameter int HEALTH_DECAY_TICKS = 5,
   parameter int ACT_CYCLES         = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Cmd_Comida,
   input  logic       Cmd_Medicina,
   output logic       Activo_Comida,
   output logic       Activo_Medicina,
   output logic [1:0] Nivel_Comida,
   output logic [1:0] Nivel_Salud,
   output logic       Muerto,
   output logic       Tick
);

   // Counter widths; a parameter of 1 still needs a 1-bit register.
   localparam int PW = (TICK_DIV > 1)           ? $clog2(TICK_DIV)           : 1;
   localparam int FW = (FOOD_DECAY_TICKS > 1)   ? $clog2(FOOD_DECAY_TICKS)   : 1;
   localparam int HW = (HEALTH_DECAY_TICKS > 1) ? $clog2(HEALTH_DECAY_TICKS) : 1;
   localparam int AW = (ACT_CYCLES > 1)         ? $clog2(ACT_CYCLES)         : 1;

   typedef enum logic [1:0] {IDLE, FEED, HEAL, DEAD} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pres_q, pres_d;
   logic [FW-1:0] food_cnt_q, food_cnt_d;
   logic [HW-1:0] health_cnt_q, health_cnt_d;
   logic [AW-1:0] act_q, act_d;
   logic [1:0]    food_q, food_d;
   logic [1:0]    health_q, health_d;
   logic          tick;
   logic          cmd_feed, cmd_heal;
`ifdef NEEDS_CMD_QUEUE_EN
   logic          pend_feed_q, pend_feed_d;
   logic          pend_heal_q, pend_heal_d;
`endif

   function automatic logic [1:0] sat_inc(input logic [1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] v);
      return (v == 2'd0) ? v : v - 2'd1;
   endfunction

   // Next-state logic: prescaler, decay counters, command handling, death.
   always_comb begin
      state_d      = state_q;
      pres_d       = pres_q;
      food_cnt_d   = food_cnt_q;
      health_cnt_d = health_cnt_q;
      act_d        = act_q;
      food_d       = food_q;
      health_d     = health_q;
      tick         = 1'b0;
      cmd_feed     = 1'b0;
      cmd_heal     = 1'b0;
`ifdef NEEDS_CMD_QUEUE_EN
      pend_feed_d  = pend_feed_q;
      pend_heal_d  = pend_heal_q;
`endif
      if (state_q != DEAD) begin
         tick   = (pres_q == PW'(TICK_DIV - 1));
         pres_d = tick ? '0 : pres_q + PW'(1);

         // Food decay is suspended while a feed action is running.
         if (state_q != FEED && tick) begin
            if (food_cnt_q == FW'(FOOD_DECAY_TICKS - 1)) begin
               food_cnt_d = '0;
               food_d     = sat_dec(food_q);
            end else begin
               food_cnt_d = food_cnt_q + FW'(1);
            end
         end

         // Health only starves while the food level sits at zero.
         if (food_q != 2'd0) begin
            health_cnt_d = '0;
         end else if (tick) begin
            if (health_cnt_q == HW'(HEALTH_DECAY_TICKS - 1)) begin
               health_cnt_d = '0;
               health_d     = sat_dec(health_q);
            end else begin
               health_cnt_d = health_cnt_q + HW'(1);
            end
         end

         case (state_q)
            IDLE: begin
`ifdef NEEDS_CMD_QUEUE_EN
               // A pending command takes the place of any live one this cycle.
               cmd_feed    = pend_feed_q | (~pend_heal_q & Cmd_Comida);
               cmd_heal    = pend_heal_q | (~pend_feed_q & ~Cmd_Comida & Cmd_Medicina);
               pend_feed_d = 1'b0;
               pend_heal_d = 1'b0;
`else
               cmd_feed = Cmd_Comida;
               cmd_heal = Cmd_Medicina & ~Cmd_Comida;
`endif
               // Increments override a decrement computed on the same edge.
               if (cmd_feed) begin
                  state_d    = FEED;
                  act_d      = '0;
                  food_d     = sat_inc(food_q);
                  food_cnt_d = '0;
               end else if (cmd_heal) begin
                  state_d  = HEAL;
                  act_d    = '0;
                  health_d = sat_inc(health_q);
               end
            end
            FEED, HEAL: begin
               if (act_q == AW'(ACT_CYCLES - 1)) begin
                  state_d = IDLE;
                  act_d   = '0;
               end else begin
                  act_d = act_q + AW'(1);
               end
`ifdef NEEDS_CMD_QUEUE_EN
               if (!pend_feed_q && !pend_heal_q) begin
                  if (Cmd_Comida)
                     pend_feed_d = 1'b1;
                  else if (Cmd_Medicina)
                     pend_heal_d = 1'b1;
               end
`endif
            end
            default: ;
         endcase

         // Death is taken on the very edge health reaches zero.
         if (health_d == 2'd0) begin
            state_d = DEAD;
            act_d   = '0;
`ifdef NEEDS_CMD_QUEUE_EN
            pend_feed_d = 1'b0;
            pend_heal_d = 1'b0;
`endif
         end
      end
   end

   // State and level registers with immediate reset to a healthy, idle pet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         pres_q       <= '0;
         food_cnt_q   <= '0;
         health_cnt_q <= '0;
         act_q        <= '0;
         food_q       <= 2'd3;
         health_q     <= 2'd3;
`ifdef NEEDS_CMD_QUEUE_EN
         pend_feed_q  <= 1'b0;
         pend_heal_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pres_q       <= pres_d;
         food_cnt_q   <= food_cnt_d;
         health_cnt_q <= health_cnt_d;
         act_q        <= act_d;
         food_q       <= food_d;
         health_q     <= health_d;
`ifdef NEEDS_CMD_QUEUE_EN
         pend_feed_q  <= pend_feed_d;
         pend_heal_q  <= pend_heal_d;
`endif
      end
   end

   assign Activo_Comida   = (state_q == FEED);
   assign Activo_Medicina = (state_q == HEAL);
   assign Muerto          = (state_q == DEAD);
   assign Nivel_Comida    = food_q;
   assign Nivel_Salud     = health_q;
   assign Tick            = tick;

endmodule
